// File: rtl/eq1_udp_cmp_pkg.sv
// Shared types and helpers for the eq1_udp_cmp registered equality comparator.
package eq1_udp_cmp_pkg;

  localparam int MAX_WIDTH = 64;

  // Index width for a given bit count, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  localparam int RES_IDX_W = clog2_min1(MAX_WIDTH);

  // Word-level compare result, wide enough for any supported WIDTH.
  typedef struct packed {
    logic                 eq;
    logic [RES_IDX_W-1:0] mis_idx;
    logic [RES_IDX_W:0]   mis_cnt;
  } cmp_res_t;

endpackage

// File: rtl/eq1_cell.sv
// 1-bit equality cell written as a truth table; non-0/1 inputs give X, synthesis sees XNOR.
module eq1_cell (
  input  logic a,
  input  logic b,
  output logic y
);

  always_comb begin
    case ({a, b})
      2'b00:   y = 1'b1;
      2'b01:   y = 1'b0;
      2'b10:   y = 1'b0;
      2'b11:   y = 1'b1;
      default: y = 1'bx;
    endcase
  end

endmodule

// File: rtl/eq1_udp_cmp.sv
// Registered N-bit equality comparator: per-bit cells, reduction, lowest-mismatch encode.
// Optional sticky mismatch flag enabled by defining EQ1_UDP_CMP_STICKY_EN.
module eq1_udp_cmp
  import eq1_udp_cmp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDX_W = clog2_min1(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
`ifdef EQ1_UDP_CMP_STICKY_EN
  input  logic             sticky_clr,
  output logic             sticky_mis,
`endif
  output logic             out_valid,
  output logic             eq,
  output logic [WIDTH-1:0] eq_vec,
  output logic [IDX_W-1:0] mis_idx,
  output logic [IDX_W:0]   mis_cnt
);

  logic [WIDTH-1:0] eq_vec_c;
  cmp_res_t         res_d;
  cmp_res_t         res_q;
  logic [WIDTH-1:0] eq_vec_q;
  logic             out_valid_q;

  for (genvar k = 0; k < WIDTH; k++) begin : g_cell
    eq1_cell u_cell (
      .a (i0[k]),
      .b (i1[k]),
      .y (eq_vec_c[k])
    );
  end

  // Scan from the top down so the lowest mismatching bit is written last and wins.
  always_comb begin
    // NOTE: every field gets a default before the loop, so no latch is inferred.
    res_d    = '0;
    res_d.eq = &eq_vec_c;
    for (int k = WIDTH - 1; k >= 0; k--) begin
      if (!eq_vec_c[k]) res_d.mis_idx = RES_IDX_W'(k);
      res_d.mis_cnt = res_d.mis_cnt + {{RES_IDX_W{1'b0}}, ~eq_vec_c[k]};
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
      eq_vec_q    <= '0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        res_q    <= res_d;
        eq_vec_q <= eq_vec_c;
      end
    end
  end

`ifdef EQ1_UDP_CMP_STICKY_EN
  logic sticky_q;

  // A mismatching beat sets the flag even if a clear arrives in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n)                     sticky_q <= 1'b0;
    else if (in_valid && !res_d.eq) sticky_q <= 1'b1;
    else if (sticky_clr)            sticky_q <= 1'b0;
  end

  assign sticky_mis = sticky_q;
`endif

  assign out_valid = out_valid_q;
  assign eq        = res_q.eq;
  assign eq_vec    = eq_vec_q;
  assign mis_idx   = res_q.mis_idx[IDX_W-1:0];
  assign mis_cnt   = res_q.mis_cnt[IDX_W:0];

  // Upper struct bits beyond IDX_W are constant zero for narrow instances.
  logic unused_res;
  assign unused_res = ^{res_q.mis_idx, res_q.mis_cnt};

endmodule

// File: tb/tb_eq1_udp_cmp.sv
// Self-checking bench for eq1_udp_cmp: WIDTH=8 and WIDTH=1 instances against a behavioural model.
module tb_eq1_udp_cmp;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] a8, b8;
  logic [0:0] a1, b1;

  logic       ov8, eq8, ov1, eq1;
  logic [7:0] vec8;
  logic [2:0] idx8;
  logic [3:0] cnt8;
  logic [0:0] vec1, idx1;
  logic [1:0] cnt1;

`ifdef EQ1_UDP_CMP_STICKY_EN
  logic sticky_clr;
  logic stk8, stk1;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  eq1_udp_cmp #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .i0        (a8),
    .i1        (b8),
`ifdef EQ1_UDP_CMP_STICKY_EN
    .sticky_clr(sticky_clr),
    .sticky_mis(stk8),
`endif
    .out_valid (ov8),
    .eq        (eq8),
    .eq_vec    (vec8),
    .mis_idx   (idx8),
    .mis_cnt   (cnt8)
  );

  eq1_udp_cmp #(.WIDTH(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .i0        (a1),
    .i1        (b1),
`ifdef EQ1_UDP_CMP_STICKY_EN
    .sticky_clr(sticky_clr),
    .sticky_mis(stk1),
`endif
    .out_valid (ov1),
    .eq        (eq1),
    .eq_vec    (vec1),
    .mis_idx   (idx1),
    .mis_cnt   (cnt1)
  );

  // Expected output state of one comparator instance.
  typedef struct {
    logic        ov;
    logic        eq;
    logic [63:0] vec;
    int          idx;
    int          cnt;
    logic        stk;
  } mdl_t;

  mdl_t m8, m1;

  function automatic mdl_t next_m(mdl_t m, logic rst_v, logic iv, logic clr,
                                  logic [63:0] a, logic [63:0] b, int w);
    logic [63:0] mask, diff;
    mdl_t        n;
    n    = m;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    diff = (a ^ b) & mask;
    if (!rst_v) begin
      n.ov = 1'b0; n.eq = 1'b0; n.vec = '0; n.idx = 0; n.cnt = 0; n.stk = 1'b0;
    end else begin
      n.ov = iv;
      if (iv) begin
        n.eq  = (diff == 64'd0);
        n.vec = ~diff & mask;
        n.cnt = $countones(diff);
        n.idx = 0;
        for (int k = 0; k < w; k++) begin
          if (diff[k]) begin
            n.idx = k;
            break;
          end
        end
      end
      if (iv && diff != 64'd0) n.stk = 1'b1;
      else if (clr)            n.stk = 1'b0;
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("w8.out_valid", 64'(ov8),  64'(m8.ov));
    check("w8.eq",        64'(eq8),  64'(m8.eq));
    check("w8.eq_vec",    64'(vec8), m8.vec);
    check("w8.mis_idx",   64'(idx8), 64'(m8.idx));
    check("w8.mis_cnt",   64'(cnt8), 64'(m8.cnt));
    check("w1.out_valid", 64'(ov1),  64'(m1.ov));
    check("w1.eq",        64'(eq1),  64'(m1.eq));
    check("w1.eq_vec",    64'(vec1), m1.vec);
    check("w1.mis_idx",   64'(idx1), 64'(m1.idx));
    check("w1.mis_cnt",   64'(cnt1), 64'(m1.cnt));
`ifdef EQ1_UDP_CMP_STICKY_EN
    check("w8.sticky",    64'(stk8), 64'(m8.stk));
    check("w1.sticky",    64'(stk1), 64'(m1.stk));
`endif
  endtask

  task automatic step();
    logic clr;
    clr = 1'b0;
`ifdef EQ1_UDP_CMP_STICKY_EN
    clr = sticky_clr;
`endif
    @(posedge clk);
    m8 = next_m(m8, rst_n, in_valid, clr, 64'(a8), 64'(b8), 8);
    m1 = next_m(m1, rst_n, in_valid, clr, 64'(a1), 64'(b1), 1);
    #1;
    compare_all();
  endtask

  task automatic drive(input logic v, input logic [7:0] x8, input logic [7:0] y8,
                       input logic x1, input logic y1);
    in_valid = v; a8 = x8; b8 = y8; a1 = x1; b1 = y1;
  endtask

  initial begin
    m8 = '{default: 0};
    m1 = '{default: 0};
`ifdef EQ1_UDP_CMP_STICKY_EN
    sticky_clr = 1'b0;
`endif
    // Reset with a mismatching beat presented: beat must be dropped.
    rst_n = 1'b0;
    drive(1'b1, 8'hFF, 8'h00, 1'b1, 1'b0);
    step();
    step();
    check("rst.eq_vec", 64'(vec8), 64'h0);
    rst_n = 1'b1;

    // Directed beats; WIDTH=1 walks its truth table 00,10,01,11 alongside.
    drive(1'b1, 8'hA5, 8'hA5, 1'b0, 1'b0); step();
    check("a5a5.eq_vec", 64'(vec8), 64'hFF);
    drive(1'b1, 8'hA5, 8'h25, 1'b1, 1'b0); step();
    check("a525.mis_idx", 64'(idx8), 64'd7);
    check("w1.10.eq", 64'(eq1), 64'd0);
    drive(1'b1, 8'h00, 8'hFF, 1'b0, 1'b1); step();
    check("allmis.mis_cnt", 64'(cnt8), 64'd8);
    check("allmis.mis_idx", 64'(idx8), 64'd0);
    drive(1'b1, 8'h3C, 8'h34, 1'b1, 1'b1); step();
    check("w1.11.eq", 64'(eq1), 64'd1);
    check("w1.11.valid", 64'(ov1), 64'd1);

    // Valid gap: results hold, out_valid drops for three cycles.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      step();
      check("gap.hold_idx", 64'(idx8), 64'd3);
    end

    // Reset while out_valid is high clears on that edge.
    drive(1'b1, 8'h0F, 8'h01, 1'b0, 1'b1); step();
    rst_n = 1'b0; step();
    check("rst_on_valid.eq_vec", 64'(vec8), 64'h0);
    rst_n = 1'b1;

`ifdef EQ1_UDP_CMP_STICKY_EN
    drive(1'b1, 8'h01, 8'h00, 1'b0, 1'b1); step();
    check("stk.set", 64'(stk8), 64'd1);
    drive(1'b1, 8'h55, 8'h55, 1'b1, 1'b1); step();
    step();
    check("stk.hold", 64'(stk8), 64'd1);
    sticky_clr = 1'b1;
    drive(1'b1, 8'h80, 8'h00, 1'b0, 1'b1); step();
    check("stk.set_wins", 64'(stk8), 64'd1);
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0); step();
    check("stk.clr", 64'(stk8), 64'd0);
    sticky_clr = 1'b0;
`endif

    // Randomized traffic with biased equality and occasional resets.
    for (int i = 0; i < 400; i++) begin
      logic [7:0] x, y;
      x = 8'($urandom);
      y = ($urandom_range(0, 3) == 0) ? x : (($urandom_range(0, 1) == 0) ? (x ^ 8'(1 << $urandom_range(0, 7))) : 8'($urandom));
      rst_n = ($urandom_range(0, 31) != 0);
`ifdef EQ1_UDP_CMP_STICKY_EN
      sticky_clr = ($urandom_range(0, 7) == 0);
`endif
      drive(1'($urandom_range(0, 3) != 0), x, y, 1'($urandom), 1'($urandom));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
